id_hazard_ctrl: RTL
===================

Name: id_hazard_ctrl

Overview:
Pipeline hazard controller for the instruction-decode stage. It tracks the destination register of every in-flight instruction in EX, MEM and WB, and compares it against the rs/rt fields being decoded. From that comparison it produces the stall/bubble control and the operand-forwarding selects. It sits beside the ID block and drives the PC/IF-ID write enables, the ID/EX bubble insert and the EX operand muxes.

Parameters:
FWD_EN, 1, 1 = forwarding present (stall only on load-use); 0 = no forwarding (stall on any RAW against EX/MEM/WB)
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
id_valid  in  1  decode slot holds a real instruction
id_rs  in  5  instruction[25:21] of decoding instruction
id_rt  in  5  instruction[20:16] of decoding instruction
id_uses_rt  in  1  rt is a source operand (R-type, store, branch)
id_wreg  in  1  decoding instruction writes the register file
id_m2reg  in  1  decoding instruction is a load
id_dest  in  5  selected destination (RdRt from ID)
flush  in  1  kill decoding instruction (taken branch/jump)
stall  out  1  hold PC and IF/ID register this cycle
bubble  out  1  insert NOP into ID/EX this cycle
fwd_a  out  2  operand A select: 00 regfile, 01 EX result, 10 MEM result, 11 WB result
fwd_b  out  2  operand B select, same encoding
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Internal tracking record per stage S in {EX, MEM, WB}: v_S, wreg_S, m2reg_S, dest_S[4:0].
- Writer(S) = v_S & wreg_S & (dest_S != 0). Register 0 never creates a hazard and is never forwarded.
- match_rs(S) = Writer(S) & (id_rs == dest_S).
- match_rt(S) = Writer(S) & id_uses_rt & (id_rt == dest_S).
- Hazard terms are gated by id_valid; an invalid decode slot never stalls and forwards 00.
- FWD_EN=1:
  - stall = id_valid & !flush & m2reg_EX & (match_rs(EX) | match_rt(EX)). This is load-use only, max 1 cycle.
  - fwd_a priority: EX (non-load) -> 01, else MEM -> 10, else WB -> 11, else 00. fwd_b is the same using match_rt.
  - A load in EX is never forwarded from EX; the stall covers it and the next cycle forwards from MEM (10).
- FWD_EN=0:
  - stall = id_valid & !flush & any match in EX, MEM or WB. Max 3 consecutive cycles.
  - fwd_a = fwd_b = 00 always.
- bubble = stall | flush.
- stall, bubble and fwd_* are combinational from current inputs and tracking state, valid in the same cycle.
- Rising clk, not in reset, advance all stages in the same edge:
  - WB <= MEM
  - MEM <= EX
  - EX <= {id_valid & !stall & !flush, id_wreg, id_m2reg, id_dest}
- A stalled instruction is re-presented by the unchanged IF/ID register and re-evaluated next cycle.
- flush has priority over stall: stall = 0, EX receives a bubble, and the tracking state of older stages is unaffected.
- stall_cnt increments by 1 on each rising edge where stall = 1. It holds at 2^CNT_W-1 and does not wrap.
- Reset (asynchronous, immediate, also mid-stall):
  - all v_S = 0, wreg_S = m2reg_S = 0, dest_S = 0, stall_cnt = 0.
  - Outputs therefore go to stall = 0, bubble = flush, fwd_a = fwd_b = 00 without waiting for clk.
- Simultaneous match in several stages: the youngest stage (EX) wins the forward select. The stall decision uses the EX record only when FWD_EN=1, and any stage when FWD_EN=0.
- rs == rt, both matching: fwd_a and fwd_b take the same value.

Test Plan:
1. Reset with FWD_EN=1: assert rst mid-cycle while a load-use stall is active -> stall drops to 0 immediately, fwd_a = fwd_b = 00, stall_cnt = 0.
2. FWD_EN=1 load-use: lw $2,0($1) then add $3,$2,$4 -> stall = 1, bubble = 1 for exactly one cycle, then fwd_a = 10, stall_cnt = 1.
3. FWD_EN=1 ALU chain:
   - add $5,$1,$1 then sub $6,$5,$5 -> stall = 0, fwd_a = fwd_b = 01.
   - Third instruction or $7,$5,$0 -> fwd_a = 10, fwd_b = 00.
4. Register 0: addi $0,$0,1 then add $8,$0,$0 -> no stall, fwd_a = fwd_b = 00.
5. FWD_EN=0: add $2,... then add $9,$2,$2 -> stall for 3 consecutive cycles, then stall = 0 with fwd 00, stall_cnt = 3.
6. Flush during a load-use hazard: flush = 1 with a matching lw in EX -> stall = 0, bubble = 1, and the next cycle v_EX = 0 (no hazard from the flushed instruction).

Source files
------------

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard controller: tracks in-flight destinations in EX/MEM/WB and
// derives stall, bubble and operand-forward selects for the instruction in ID.
module id_hazard_ctrl #(
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic [4:0]       id_dest,
  input  logic             flush,
  output logic             stall,
  output logic             bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  // Stage index: 0 = EX (youngest), 1 = MEM, 2 = WB
  localparam int NS = 3;

  logic [NS-1:0]      v_reg;
  logic [NS-1:0]      wreg_reg;
  logic [NS-1:0]      m2reg_reg;
  logic [NS-1:0][4:0] dest_reg;
  logic [CNT_W-1:0]   stall_cnt_reg;

  logic [NS-1:0] match_rs;
  logic [NS-1:0] match_rt;

  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_match
      logic writer;
      assign writer       = v_reg[gi] & wreg_reg[gi] & (dest_reg[gi] != 5'd0);
      assign match_rs[gi] = id_valid & writer & (id_rs == dest_reg[gi]);
      assign match_rt[gi] = id_valid & writer & id_uses_rt & (id_rt == dest_reg[gi]);
    end
  endgenerate

  // Youngest matching stage wins; a load still in EX has no result to forward yet.
  function automatic logic [1:0] fwd_sel(input logic [NS-1:0] m, input logic ex_load);
    if (m[0] && !ex_load) return 2'b01;
    else if (m[1])        return 2'b10;
    else if (m[2])        return 2'b11;
    else                  return 2'b00;
  endfunction

  always_comb begin
    stall = 1'b0;
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_EN) begin
      stall = id_valid & ~flush & m2reg_reg[0] & (match_rs[0] | match_rt[0]);
      fwd_a = fwd_sel(match_rs, m2reg_reg[0]);
      fwd_b = fwd_sel(match_rt, m2reg_reg[0]);
    end else begin
      stall = id_valid & ~flush & (|(match_rs | match_rt));
    end
  end

  assign bubble    = stall | flush;
  assign stall_cnt = stall_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_reg         <= '0;
      wreg_reg      <= '0;
      m2reg_reg     <= '0;
      dest_reg      <= '0;
      stall_cnt_reg <= '0;
    end else begin
      v_reg     <= {v_reg[NS-2:0], id_valid & ~stall & ~flush};
      wreg_reg  <= {wreg_reg[NS-2:0], id_wreg};
      m2reg_reg <= {m2reg_reg[NS-2:0], id_m2reg};
      dest_reg  <= {dest_reg[NS-2:0], id_dest};
      if (stall && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

endmodule
